// File: rtl/sd_cmd_engine_if.sv
// sd_cmd_engine_if: command request, CMD pad and status bundle for the SD command engine
interface sd_cmd_engine_if;
    logic         istart;
    logic [5:0]   icmd_index;
    logic [31:0]  iarg;
    logic [1:0]   iresp_type;
    logic         icmd;
    logic         ocmd;
    logic         ocmd_oe;
    logic         obusy;
    logic         odone;
    logic         ocrc_err;
    logic         otimeout;
    logic [127:0] oresp;
    modport master (
        output istart, icmd_index, iarg, iresp_type, icmd,
        input  ocmd, ocmd_oe, obusy, odone, ocrc_err, otimeout, oresp
    );
    modport slave (
        input  istart, icmd_index, iarg, iresp_type, icmd,
        output ocmd, ocmd_oe, obusy, odone, ocrc_err, otimeout, oresp
    );
endinterface

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: serializes SD commands with CRC7, receives/validates responses, enforces NCC gap
module sd_cmd_engine #(
    parameter int RESP_TIMEOUT = 64,
    parameter int NCC_CYCLES   = 8
) (
    input logic            iclk,
    input logic            irst,
    sd_cmd_engine_if.slave bus
);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_NCC} state_t;
    state_t         r_state, w_next;
    logic [39:0]    r_frame;
    logic [1:0]     r_type;
    logic [6:0]     r_crc;
    logic [7:0]     r_bit;
    logic [TW-1:0]  r_tmo;
    logic [126:0]   r_rx;
    logic           r_done, r_crc_err, r_timeout;
    logic [127:0]   r_resp;
    logic [127:0]   w_full;
    logic           w_r2, w_tx_last, w_rx_last, w_ncc_last, w_tmo_hit, w_rx_crc_en, w_rx_err;

    function automatic logic [6:0] f_crc7(input logic [6:0] c, input logic b);
        return {c[5:3], c[2] ^ b ^ c[6], c[1:0], b ^ c[6]};
    endfunction

    assign w_r2        = r_type == 2'b10;
    assign w_full      = {r_rx, bus.icmd};
    assign w_tx_last   = r_bit == 8'd47;
    assign w_rx_last   = r_bit == (w_r2 ? 8'd135 : 8'd47);
    assign w_ncc_last  = r_bit == 8'(NCC_CYCLES - 1);
    assign w_tmo_hit   = r_tmo == TW'(RESP_TIMEOUT);
    // CRC covers bits 2..40 of a 48-bit reply (start bit 0 leaves it unchanged) or bits 9..128 of R2
    assign w_rx_crc_en = w_r2 ? (r_bit >= 8'd8 && r_bit <= 8'd127) : r_bit <= 8'd39;
    assign w_rx_err    = !bus.icmd || (r_type[0] != r_type[1] && r_crc != w_full[7:1]) ||
                         (r_type == 2'b01 && w_full[46]);

    assign bus.odone    = r_done;
    assign bus.ocrc_err = r_crc_err;
    assign bus.otimeout = r_timeout;
    assign bus.oresp    = r_resp;

    // state register; reset aborts any transaction and releases the line
    always_ff @(posedge iclk) begin
        r_state <= irst ? S_IDLE : w_next;
    end

    // next state and CMD line drive; the line is only driven while the frame is on the wire
    always_comb begin
        w_next      = r_state;
        bus.ocmd    = 1'b1;
        bus.ocmd_oe = 1'b0;
        bus.obusy   = r_state != S_IDLE;
        case (r_state)
            S_IDLE: w_next = bus.istart ? S_TX : S_IDLE;
            S_TX: begin
                bus.ocmd_oe = 1'b1;
                bus.ocmd    = r_bit < 8'd40 ? r_frame[39] : r_bit < 8'd47 ? r_crc[6] : 1'b1;
                if (w_tx_last) w_next = r_type == 2'b00 ? S_NCC : S_WAIT;
            end
            S_WAIT: w_next = !bus.icmd ? S_RX : w_tmo_hit ? S_NCC : S_WAIT;
            S_RX: if (w_rx_last) w_next = S_NCC;
            S_NCC: if (w_ncc_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // datapath: frame/CRC shifting, response capture, counters and status flags
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_frame   <= '0;
            r_type    <= '0;
            r_crc     <= '0;
            r_bit     <= '0;
            r_tmo     <= '0;
            r_rx      <= '0;
            r_done    <= 1'b0;
            r_crc_err <= 1'b0;
            r_timeout <= 1'b0;
            r_resp    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.istart) begin
                    r_frame   <= {2'b01, bus.icmd_index, bus.iarg};
                    r_type    <= bus.iresp_type;
                    r_crc     <= '0;
                    r_bit     <= '0;
                    r_crc_err <= 1'b0;
                    r_timeout <= 1'b0;
                    r_resp    <= '0;
                end
                S_TX: begin
                    r_bit   <= w_tx_last ? 8'd0 : r_bit + 8'd1;
                    r_frame <= {r_frame[38:0], 1'b0};
                    r_crc   <= r_bit < 8'd40 ? f_crc7(r_crc, r_frame[39]) : {r_crc[5:0], 1'b0};
                    r_tmo   <= TW'(1);
                end
                S_WAIT: begin
                    r_tmo <= r_tmo + TW'(1);
                    r_bit <= 8'd1;
                    r_rx  <= '0;
                    r_crc <= '0;
                    if (bus.icmd && w_tmo_hit) begin
                        r_timeout <= 1'b1;
                        r_bit     <= 8'd0;
                    end
                end
                S_RX: begin
                    r_rx  <= w_full[126:0];
                    r_bit <= w_rx_last ? 8'd0 : r_bit + 8'd1;
                    if (w_rx_crc_en) r_crc <= f_crc7(r_crc, bus.icmd);
                    if (w_rx_last) begin
                        r_crc_err <= w_rx_err;
                        r_resp    <= w_r2 ? w_full : {90'd0, w_full[45:8]};
                    end
                end
                S_NCC: begin
                    r_bit  <= r_bit + 8'd1;
                    r_done <= w_ncc_last;
                end
                default: ;
            endcase
        end
    end
endmodule
